// File: rtl/spi_monitor_bridge.sv
// SPI mode-1, LSB-first monitor bridge: streams a bus snapshot plus a queued UART byte to the
// host MCU and collects host control bits plus UART bytes from MOSI, all on the system clock.
module spi_monitor_bridge #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_SIGNALS = 4,
  parameter int IN_SIGNALS  = 4,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4
) (
  input  logic                   MCLK_IN,
  input  logic                   RESET_IN,
  input  logic                   SPICLK_IN,
  input  logic                   SPISI_IN,
  input  logic                   SPISS_IN,
  input  logic [ADDR_WIDTH-1:0]  ADDR_IN,
  input  logic [DATA_WIDTH-1:0]  DATA_IN,
  input  logic [OUT_SIGNALS-1:0] OUTPUT_SIGNAL_IN,
  input  logic                   UART_SEND_TRIGGER_IN,
  input  logic [7:0]             UART_SEND_BYTE_IN,
  input  logic                   UART_RECEIVE_CAPTURE_IN,
  output logic [IN_SIGNALS-1:0]  INPUT_SIGNAL,
  output logic                   SPISO,
  output logic                   SPISO_OE,
  output logic                   UART_SEND_BUSY,
  output logic                   UART_RECEIVED,
  output logic [7:0]             UART_RECEIVE_BYTE
);

  localparam int F   = ADDR_WIDTH + DATA_WIDTH + OUT_SIGNALS + 4 + 8;
  localparam int R   = IN_SIGNALS + 10;
  localparam int CW  = $clog2(F + 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TLW = $clog2(TX_DEPTH + 1);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RLW = $clog2(RX_DEPTH + 1);

  localparam logic [CW-1:0] F_CNT  = CW'(F);
  localparam logic [CW-1:0] R_CNT  = CW'(R);
  localparam logic [CW-1:0] R_LAST = CW'(R - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_DONE} state_t;

  // Pin synchronisers; select resets high so a select held through reset never opens a frame.
  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic ss_s1_q, ss_s2_q, ss_h_q;
  logic si_s1_q, si_s2_q;

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_h_q  <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_h_q    <= 1'b1;
      si_s1_q   <= 1'b0;
      si_s2_q   <= 1'b0;
    end else begin
      sclk_s1_q <= SPICLK_IN;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      ss_s1_q   <= SPISS_IN;
      ss_s2_q   <= ss_s1_q;
      ss_h_q    <= ss_s2_q;
      si_s1_q   <= SPISI_IN;
      si_s2_q   <= si_s1_q;
    end
  end

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  assign sclk_rise = sclk_s2_q & ~sclk_h_q;
  assign sclk_fall = ~sclk_s2_q & sclk_h_q;
  assign ss_rise   = ss_s2_q & ~ss_h_q;
  assign ss_fall   = ~ss_s2_q & ss_h_q;

  // FIFO state
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [TLW-1:0] tx_level_q;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [RLW-1:0] rx_level_q;

  logic tx_full, tx_nonempty, tx_push, tx_pop;
  logic rx_full, rx_nonempty, rx_push, rx_pop;
  logic [7:0] tx_head;

  assign tx_full     = (tx_level_q == TLW'(TX_DEPTH));
  assign tx_nonempty = (tx_level_q != '0);
  assign rx_full     = (rx_level_q == RLW'(RX_DEPTH));
  assign rx_nonempty = (rx_level_q != '0);
  assign tx_head     = tx_mem[tx_rp_q];

  // Frame engine state
  state_t          state_q;
  logic [F-1:0]    tx_sh_q;
  logic [CW-1:0]   tx_bits_q, rx_bits_q;
  logic [R-2:1]    rx_q;
  logic            oe_q;
  logic [IN_SIGNALS-1:0] in_sig_q;
  logic            tx_frame_valid_q;
  logic            ovf_q, ovf_rep_q, ovf_new_q;

  logic [F-1:0] snap;
  logic         rx_shift, rx_done, rx_push_req, rx_ovf;
  logic [7:0]   rx_byte;

  assign snap = {(tx_nonempty ? tx_head : 8'h00), 1'b0, ovf_q, rx_full, tx_nonempty,
                 OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN};

  // The last MOSI bit is taken straight from the synchroniser; bit 0 is never stored.
  assign rx_shift    = (state_q == S_SHIFT) && !ss_fall && sclk_fall && (rx_bits_q < R_CNT);
  assign rx_done     = rx_shift && (rx_bits_q == R_LAST);
  assign rx_byte     = {si_s2_q, rx_q[R-2:R-8]};
  assign rx_push_req = rx_done && rx_q[IN_SIGNALS+1];
  assign rx_ovf      = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      state_q          <= S_IDLE;
      tx_sh_q          <= '0;
      tx_bits_q        <= '0;
      rx_bits_q        <= '0;
      rx_q             <= '0;
      oe_q             <= 1'b0;
      in_sig_q         <= '0;
      tx_frame_valid_q <= 1'b0;
      ovf_q            <= 1'b0;
      ovf_rep_q        <= 1'b0;
      ovf_new_q        <= 1'b0;
    end else begin
      if (rx_ovf) begin
        ovf_q     <= 1'b1;
        ovf_new_q <= 1'b1;
      end
      if (ss_fall) begin
        state_q <= S_DONE;
        tx_sh_q <= '0;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ss_rise) begin
              state_q          <= S_ARMED;
              oe_q             <= 1'b1;
              tx_bits_q        <= '0;
              rx_bits_q        <= '0;
              tx_frame_valid_q <= 1'b0;
              ovf_rep_q        <= 1'b0;
              ovf_new_q        <= 1'b0;
            end
          end
          S_ARMED: begin
            if (sclk_rise) begin
              state_q          <= S_SHIFT;
              tx_sh_q          <= snap;
              tx_bits_q        <= CW'(1);
              tx_frame_valid_q <= tx_nonempty;
              ovf_rep_q        <= ovf_q;
            end
          end
          S_SHIFT: begin
            if (sclk_rise) begin
              tx_sh_q <= {1'b0, tx_sh_q[F-1:1]};
              if (tx_bits_q != F_CNT) tx_bits_q <= tx_bits_q + CW'(1);
            end
            if (rx_shift) begin
              rx_bits_q <= rx_bits_q + CW'(1);
              for (int i = 1; i <= R - 2; i++) begin
                if (rx_bits_q == CW'(i)) rx_q[i] <= si_s2_q;
              end
            end
            if (rx_done) in_sig_q <= rx_q[IN_SIGNALS:1];
          end
          S_DONE: begin
            state_q <= S_IDLE;
            // Only a completed frame that actually reported the overflow acknowledges it.
            if ((tx_bits_q == F_CNT) && ovf_rep_q && !ovf_new_q) ovf_q <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // TX FIFO: a byte leaves only after a full-length frame has carried it.
  assign tx_pop  = (state_q == S_DONE) && (tx_bits_q == F_CNT) && tx_frame_valid_q && tx_nonempty;
  assign tx_push = UART_SEND_TRIGGER_IN && (!tx_full || tx_pop);

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_level_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level_q <= tx_level_q + TLW'(1);
        2'b01:   tx_level_q <= tx_level_q - TLW'(1);
        default: tx_level_q <= tx_level_q;
      endcase
    end
  end

  always_ff @(posedge MCLK_IN) begin
    if (tx_push) tx_mem[tx_wp_q] <= UART_SEND_BYTE_IN;
  end

  // RX FIFO: a same-cycle CPU pop frees the slot for an incoming byte.
  assign rx_pop  = UART_RECEIVE_CAPTURE_IN && rx_nonempty;
  assign rx_push = rx_push_req && (!rx_full || rx_pop);

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_level_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + RAW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RAW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level_q <= rx_level_q + RLW'(1);
        2'b01:   rx_level_q <= rx_level_q - RLW'(1);
        default: rx_level_q <= rx_level_q;
      endcase
    end
  end

  always_ff @(posedge MCLK_IN) begin
    if (rx_push) rx_mem[rx_wp_q] <= rx_byte;
  end

  assign INPUT_SIGNAL      = in_sig_q;
  assign SPISO             = tx_sh_q[0];
  assign SPISO_OE          = oe_q;
  assign UART_SEND_BUSY    = tx_full;
  assign UART_RECEIVED     = rx_nonempty;
  assign UART_RECEIVE_BYTE = rx_nonempty ? rx_mem[rx_rp_q] : 8'h00;

endmodule
